// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - shared types and constants for the RGMII receive path
package rgmii_pkg;

    typedef enum logic [1:0] {
        DROP = 2'd0,
        IDLE = 2'd1,
        PRE  = 2'd2,
        DATA = 2'd3
    } rx_state_t;

    localparam logic [3:0] NIB_PRE = 4'h5;
    localparam logic [3:0] NIB_SFD = 4'hD;

    localparam int LEN_W = 16;
    localparam int CNT_W = 16;

endpackage

// File: rtl/rgmii_rx_stats.sv
// rtl/rgmii_rx_stats.sv - wrapping good/error frame counters
module rgmii_rx_stats
    import rgmii_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             good_stb,
    input  logic             err_stb,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (good_stb)
                good_cnt <= good_cnt + CNT_W'(1);
            if (err_stb)
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rgmii_rx_deframer.sv
// rtl/rgmii_rx_deframer.sv - RGMII nibble stream to framed byte stream with SFD pulse
module rgmii_rx_deframer
    import rgmii_pkg::*;
#(
    parameter int MIN_PRE_NIBBLES = 7,
    parameter int MAX_LEN         = 1522
) (
    input  logic             rgmii_rxclk,
    input  logic             rst_n,
    input  logic             rgmii_rxctrl,
    input  logic [3:0]       rgmii_rxdata,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_sof,
    output logic             rx_eof,
    output logic             rx_err,
    output logic [LEN_W-1:0] frame_len,
    output logic             sfd_pulse,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0]       MIN_PRE = 4'(MIN_PRE_NIBBLES);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);

    rx_state_t        state;
    logic [3:0]       pre_cnt;
    logic             phase;
    logic [3:0]       low_nib;
    logic [7:0]       hold;
    logic             hold_vld;
    logic [LEN_W-1:0] byte_cnt;
    logic             good_stb;
    logic             err_stb;

    always_ff @(posedge rgmii_rxclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DROP;
            pre_cnt   <= '0;
            phase     <= 1'b0;
            low_nib   <= '0;
            hold      <= '0;
            hold_vld  <= 1'b0;
            byte_cnt  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_err    <= 1'b0;
            frame_len <= '0;
            sfd_pulse <= 1'b0;
            good_stb  <= 1'b0;
            err_stb   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_err    <= 1'b0;
            sfd_pulse <= 1'b0;
            good_stb  <= 1'b0;
            err_stb   <= 1'b0;
            case (state)
                DROP: begin
                    if (!rgmii_rxctrl)
                        state <= IDLE;
                end
                IDLE: begin
                    if (rgmii_rxctrl) begin
                        if (rgmii_rxdata == NIB_PRE) begin
                            state   <= PRE;
                            pre_cnt <= 4'd1;
                        end else begin
                            state   <= DROP;
                            err_stb <= 1'b1;
                        end
                    end
                end
                PRE: begin
                    if (!rgmii_rxctrl) begin
                        state <= IDLE;
                    end else if (rgmii_rxdata == NIB_PRE) begin
                        if (pre_cnt != 4'hF)
                            pre_cnt <= pre_cnt + 4'd1;
                    end else if (rgmii_rxdata == NIB_SFD && pre_cnt >= MIN_PRE) begin
                        state     <= DATA;
                        sfd_pulse <= 1'b1;
                        byte_cnt  <= '0;
                        phase     <= 1'b0;
                        hold_vld  <= 1'b0;
                    end else begin
                        state   <= DROP;
                        err_stb <= 1'b1;
                    end
                end
                DATA: begin
                    if (!rgmii_rxctrl) begin
                        // A dangling low nibble marks the frame bad but the held byte still goes out.
                        state    <= IDLE;
                        hold_vld <= 1'b0;
                        if (hold_vld) begin
                            rx_data   <= hold;
                            rx_valid  <= 1'b1;
                            rx_sof    <= (byte_cnt == LEN_W'(1));
                            rx_eof    <= 1'b1;
                            rx_err    <= phase;
                            frame_len <= byte_cnt;
                            good_stb  <= !phase;
                            err_stb   <= phase;
                        end else begin
                            err_stb <= 1'b1;
                        end
                    end else if (!phase) begin
                        low_nib <= rgmii_rxdata;
                        phase   <= 1'b1;
                    end else begin
                        phase    <= 1'b0;
                        hold     <= {rgmii_rxdata, low_nib};
                        hold_vld <= 1'b1;
                        byte_cnt <= (byte_cnt == '1) ? byte_cnt : byte_cnt + LEN_W'(1);
                        if (hold_vld) begin
                            rx_data  <= hold;
                            rx_valid <= 1'b1;
                            rx_sof   <= (byte_cnt == LEN_W'(1));
                        end
                        // Completing one byte past the limit closes the frame on the held byte.
                        if (byte_cnt == MAX_L) begin
                            rx_eof    <= 1'b1;
                            rx_err    <= 1'b1;
                            frame_len <= byte_cnt;
                            err_stb   <= 1'b1;
                            hold_vld  <= 1'b0;
                            state     <= DROP;
                        end
                    end
                end
                default: state <= DROP;
            endcase
        end
    end

    rgmii_rx_stats u_stats (
        .clk      (rgmii_rxclk),
        .rst_n    (rst_n),
        .good_stb (good_stb),
        .err_stb  (err_stb),
        .good_cnt (good_cnt),
        .err_cnt  (err_cnt)
    );

endmodule

// File: tb/tb_rgmii_rx_deframer.sv
// tb/tb_rgmii_rx_deframer.sv - scoreboard bench for rgmii_rx_deframer
module tb_rgmii_rx_deframer;

    localparam int MAX_LEN = 1522;

    logic        rgmii_rxclk;
    logic        rst_n;
    logic        rgmii_rxctrl;
    logic [3:0]  rgmii_rxdata;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_err;
    logic [15:0] frame_len;
    logic        sfd_pulse;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   sfd_seen    = 0;
    int   sfd_base    = 0;

    rgmii_rx_deframer #(.MIN_PRE_NIBBLES(7), .MAX_LEN(MAX_LEN)) dut (
        .rgmii_rxclk  (rgmii_rxclk),
        .rst_n        (rst_n),
        .rgmii_rxctrl (rgmii_rxctrl),
        .rgmii_rxdata (rgmii_rxdata),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_sof       (rx_sof),
        .rx_eof       (rx_eof),
        .rx_err       (rx_err),
        .frame_len    (frame_len),
        .sfd_pulse    (sfd_pulse),
        .good_cnt     (good_cnt),
        .err_cnt      (err_cnt)
    );

    initial rgmii_rxclk = 1'b0;
    always #5 rgmii_rxclk = ~rgmii_rxclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        exp_t e;
        if (rst_n) begin
            if (sfd_pulse)
                sfd_seen++;
            if (!rx_valid && (rx_sof || rx_eof || rx_err))
                check("qual_without_valid", {29'd0, rx_sof, rx_eof, rx_err}, 32'd0);
            if (rx_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_byte", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, e.d});
                    check("rx_sof", {31'd0, rx_sof}, {31'd0, e.sof});
                    check("rx_eof", {31'd0, rx_eof}, {31'd0, e.eof});
                    check("rx_err", {31'd0, rx_err}, {31'd0, e.err});
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge rgmii_rxclk);
        sample();
    endtask

    task automatic drive(input logic c, input logic [3:0] n);
        tick();
        rgmii_rxctrl = c;
        rgmii_rxdata = n;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 4'h0);
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        rgmii_rxctrl = 1'b0;
        rgmii_rxdata = 4'h0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        sfd_base = sfd_seen;
    endtask

    task automatic send_frame(input int npre, input int nbytes, input bit odd, input bit expect_out);
        logic [7:0] b;
        int         n_exp;
        bit         bad;
        n_exp = (nbytes > MAX_LEN) ? MAX_LEN : nbytes;
        bad   = odd || (nbytes > MAX_LEN);
        for (int i = 0; i < npre; i++)
            drive(1'b1, 4'h5);
        drive(1'b1, 4'hD);
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom);
            if (expect_out && i < n_exp)
                sb.push_back('{d: b, sof: (i == 0), eof: (i == n_exp - 1),
                               err: (i == n_exp - 1) && bad});
            drive(1'b1, b[3:0]);
            drive(1'b1, b[7:4]);
        end
        if (odd)
            drive(1'b1, 4'($urandom));
        drive(1'b0, 4'h0);
    endtask

    task automatic finish_scenario(input string tag, input int exp_len, input int exp_good,
                                   input int exp_err, input int exp_sfd);
        idle(6);
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
        check({tag, "_frame_len"}, {16'd0, frame_len}, exp_len);
        check({tag, "_good_cnt"}, {16'd0, good_cnt}, exp_good);
        check({tag, "_err_cnt"}, {16'd0, err_cnt}, exp_err);
        check({tag, "_sfd_count"}, sfd_seen - sfd_base, exp_sfd);
    endtask

    initial begin
        logic [7:0] b;
        rst_n        = 1'b0;
        rgmii_rxctrl = 1'b0;
        rgmii_rxdata = 4'h0;
        #1;
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_sfd_pulse", {31'd0, sfd_pulse}, 32'd0);
        check("rst_frame_len", {16'd0, frame_len}, 32'd0);
        check("rst_good_cnt", {16'd0, good_cnt}, 32'd0);
        check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        apply_reset();

        send_frame(15, 60, 1'b0, 1'b1);
        finish_scenario("clean", 60, 1, 0, 1);

        apply_reset();
        send_frame(3, 60, 1'b0, 1'b0);
        finish_scenario("short_pre", 0, 0, 1, 0);

        apply_reset();
        send_frame(15, 60, 1'b1, 1'b1);
        finish_scenario("odd_nibble", 60, 0, 1, 1);

        apply_reset();
        send_frame(15, MAX_LEN + 1, 1'b0, 1'b1);
        finish_scenario("over_len", MAX_LEN, 0, 1, 1);

        apply_reset();
        for (int i = 0; i < 15; i++)
            drive(1'b1, 4'h5);
        drive(1'b1, 4'hD);
        for (int i = 0; i < 26; i++) begin
            if (i == 22)
                rst_n = 1'b1;
            b = 8'($urandom);
            if (i < 19)
                sb.push_back('{d: b, sof: (i == 0), eof: 1'b0, err: 1'b0});
            drive(1'b1, b[3:0]);
            drive(1'b1, b[7:4]);
            if (i == 19) begin
                tick();
                #1 rst_n = 1'b0;
                #1;
                check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
                check("midrst_rx_eof", {31'd0, rx_eof}, 32'd0);
                check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
                check("midrst_frame_len", {16'd0, frame_len}, 32'd0);
            end
        end
        drive(1'b0, 4'h0);
        sfd_base = sfd_seen;
        finish_scenario("midrst_cut", 0, 0, 0, 0);
        send_frame(15, 60, 1'b0, 1'b1);
        finish_scenario("midrst_next", 60, 1, 0, 1);

        apply_reset();
        send_frame(15, 64, 1'b0, 1'b1);
        send_frame(15, 64, 1'b0, 1'b1);
        finish_scenario("b2b", 64, 2, 0, 2);

        apply_reset();
        send_frame(7, 1, 1'b0, 1'b1);
        send_frame(7, 0, 1'b0, 1'b1);
        send_frame(6, 10, 1'b0, 1'b0);
        finish_scenario("edges", 1, 1, 2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_deframer.md
# rgmii_rx_deframer

Synthesizable receive-side deframer for the RGMII nibble stream that the switch's MAC ports and the TSU testbench transmitter produce. Samples `rgmii_rxctrl`/`rgmii_rxdata` on rising edges, one nibble per cycle, low nibble first. Strips preamble/SFD, reassembles bytes into a `rx_valid`/`rx_sof`/`rx_eof` byte stream and emits a one-cycle SFD pulse for TSU ingress timestamping. Sits between the RGMII pads and the MAC RX FIFO / TSU.

## Interface
Parameters:
- `MIN_PRE_NIBBLES`, 7: minimum count of 0x5 nibbles before SFD.
- `MAX_LEN`, 1522: maximum frame bytes, FCS included.

Ports:
- `rgmii_rxclk` in 1: the single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rgmii_rxctrl` in 1: frame-active qualifier.
- `rgmii_rxdata` in 4: nibble.
- `rx_data` out 8: output byte.
- `rx_valid` out 1: `rx_data` valid, one cycle per byte.
- `rx_sof` out 1: first byte of frame, only with `rx_valid`.
- `rx_eof` out 1: last byte of frame, only with `rx_valid`.
- `rx_err` out 1: frame bad, only with `rx_eof`.
- `frame_len` out 16: byte count, valid with `rx_eof`, held until the next `rx_eof`.
- `sfd_pulse` out 1: one cycle, registered after the SFD nibble is sampled.
- `good_cnt` out 16: frames ended without error; wraps.
- `err_cnt` out 16: errored or aborted frames; wraps.

## Operation
- States: `DROP`, `IDLE`, `PRE`, `DATA`. Reset state is `DROP`.
- `DROP`: ignore input. Leave for `IDLE` on the first cycle `rgmii_rxctrl=0`.
- `IDLE`:
  - ctrl=0: stay.
  - ctrl=1 with nibble 0x5: go to `PRE`, preamble count = 1.
  - ctrl=1 with any other nibble: go to `DROP`, `err_cnt`+1.
- `PRE`:
  - ctrl=1 with 0x5: count+1, saturating at 15.
  - ctrl=1 with 0xD and count ≥ `MIN_PRE_NIBBLES`: go to `DATA`, pulse `sfd_pulse`, clear byte count and nibble phase.
  - ctrl=1 with 0xD and count too small: go to `DROP`, `err_cnt`+1.
  - ctrl=1 with any other nibble: go to `DROP`, `err_cnt`+1.
  - ctrl=0: go to `IDLE` silently (carrier only, not counted).
- `DATA`, byte assembly:
  - Phase 0 latches the low nibble.
  - Phase 1 forms `{rgmii_rxdata, low}`.
  - The completed byte goes into a one-byte hold register. The previously held byte is emitted with `rx_valid` (`rx_sof` if it is byte 0).
- `DATA`, end of frame on ctrl=0:
  - Phase 0 and ≥1 byte held: emit the held byte with `rx_eof`, `rx_err=0`, `good_cnt`+1.
  - Phase 1 (odd nibble count): emit the held byte with `rx_eof=1`, `rx_err=1`, `err_cnt`+1; the dangling nibble is discarded.
  - Zero bytes (SFD then ctrl=0): no output, `err_cnt`+1.
  - Then go to `IDLE`.
- Over-length: when byte `MAX_LEN`+1 completes, emit held byte `MAX_LEN` with `rx_eof=1`, `rx_err=1`, `err_cnt`+1, and go to `DROP`.
- `frame_len` = number of bytes emitted in the frame, including FCS, saturating at 0xFFFF.

## Timing
- Reset values: every output is 0, both counters are 0, the hold register is cleared.
- Reset mid-frame: outputs drop to 0 immediately. No `rx_eof` is emitted for the cut frame, and it is not counted. The block waits in `DROP` for ctrl=0.
- `sfd_pulse` is high the cycle after the edge that sampled 0xD. The TSU subtracts this fixed 1-cycle offset.
- Byte latency: byte n is emitted the cycle after the edge that samples the high nibble of byte n+1. The last byte is emitted the cycle after the edge that samples ctrl=0.
- Steady state: `rx_valid` is high every second cycle.
- `rx_sof` and `rx_eof` coincide on one-byte frames.
- Back-to-back frames: one ctrl=0 cycle between frames is sufficient. The `IDLE` entry and the eof emission of the previous frame happen in the same cycle.
- Simultaneous counter events cannot occur; each frame increments exactly one counter at most once.

## Structure
- Shared package `rgmii_pkg`:
  - state enum;
  - constants `NIB_PRE=4'h5`, `NIB_SFD=4'hD`;
  - width constants for `frame_len` and the counters.
- Sub-module `rgmii_rx_stats`: the two wrapping counters, fed by one-cycle good/err strobes from the FSM.
- The FSM, nibble pack and hold register stay in the top module.

## Test plan
- Clean frame: 15×0x5, 0xD, 60 bytes, ctrl=0.
  - Expect 60 `rx_valid` bytes matching the stimulus, with `rx_sof` on byte 0 and `rx_eof` on byte 59.
  - Expect `frame_len=60`, `good_cnt=1`, and exactly one `sfd_pulse`.
- Short preamble: 3×0x5 then 0xD, then 60 bytes. Expect no `rx_valid` and `err_cnt=1`.
- Odd nibble count: 121 data nibbles. Expect 60 bytes, with `rx_eof` and `rx_err` on byte 59 and `err_cnt=1`.
- Over-length: 1523-byte frame. Expect 1522 bytes, with `rx_eof` and `rx_err` on byte 1521, `frame_len=1522`, and no output until ctrl=0.
- Reset mid-frame: assert `rst_n=0` at byte 20 while ctrl stays high.
  - Expect all outputs 0 and nothing emitted for the rest of that frame.
  - Expect the next clean frame to be received intact, `good_cnt=1`.
- Back-to-back: two 64-byte frames separated by one ctrl=0 cycle. Expect two sof/eof pairs, `good_cnt=2`, and two `sfd_pulse`s.
